sreg_deserializer: RTL and testbench
====================================

SREG_DESERIALIZER -- requirements
Module: sreg_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per frame (2..32).
REQ-002 SHALL have port sys_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port clr  input  1  synchronous frame abort and flag clear.
REQ-005 SHALL have port en  input  1  serial bit strobe; sin is sampled only on edges where en=1.
REQ-006 SHALL have port sin  input  1  serial data bit.
REQ-007 SHALL have port msb_first  input  1  bit order: 1=first bit lands in Q[WIDTH-1], 0=first bit lands in Q[0].
REQ-008 SHALL have port Q  output  WIDTH  last delivered frame.
REQ-009 SHALL have port out_valid  output  1  Q holds an unconsumed frame.
REQ-010 SHALL have port out_ready  input  1  consumer accepts Q.
REQ-011 SHALL have port busy  output  1  a frame is partially received.
REQ-012 SHALL have port overrun  output  1  sticky, a completed frame was dropped.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch.

Function
REQ-014 SHALL implement states IDLE, SHIFT, PAR; busy=1 in SHIFT and PAR only.
REQ-015 SHALL move IDLE->SHIFT on the first en=1 edge, sampling that bit and latching msb_first for the whole frame.
REQ-016 SHALL shift left (sin into LSB) when the latched order is 1, and right (sin into MSB) when it is 0.
REQ-017 SHALL hold all state on en=0 cycles mid-frame, with no timeout.
REQ-018 SHALL count sampled bits 0..WIDTH-1; on the edge sampling bit WIDTH-1 it SHALL complete the frame with zero added latency (Q and out_valid update on that same edge) and return to IDLE.
REQ-019 SHALL keep out_valid=1 and Q stable until an edge with out_valid=1 and out_ready=1, which clears out_valid.
REQ-020 SHALL, when a completion coincides with an accepting edge, load the new frame and keep out_valid=1.
REQ-021 SHALL, when a frame completes while out_valid=1 and out_ready=0, drop the frame, keep Q unchanged and set overrun=1.
REQ-022 SHALL, on clr=1, go to IDLE, zero the bit count, and clear out_valid and overrun; clr SHALL take priority over en and out_ready.
REQ-023 SHALL accept the first bit of the next frame on the edge immediately after completion.

Reset
REQ-024 SHALL, on sys_rst=1 at an edge, override all other inputs and set state=IDLE, count=0, Q=0, out_valid=0, overrun=0 and parity_err=0.
REQ-025 SHALL discard any partial frame on a mid-frame reset; the first en=1 edge after release starts a new frame.

Configuration
REQ-026 SHALL, with SREG_DESER_PARITY_EN defined, take the edge sampling bit WIDTH-1 to PAR instead of completing, and treat the next en=1 bit as even parity over the data bits.
REQ-027 SHALL, in PAR, deliver the frame per REQ-018..021 on a parity match; on a mismatch it SHALL discard the frame, pulse parity_err for one cycle and return to IDLE.
REQ-028 SHALL, without SREG_DESER_PARITY_EN, never enter PAR and tie parity_err to 0; the port list is identical in both builds.

Structure
REQ-029 SHALL place the state enum and the default WIDTH constant in the shared package sreg_pkg.
REQ-030 SHALL implement the bit counter (clear, enable, terminal-count flag) as sub-module sreg_bit_counter.

Verification
REQ-031 SHALL cover: MSB-first, out_ready=1, sin=0,1,1,0,1,1,0,1 on 8 consecutive en edges -> Q=8'h6D, out_valid high for one cycle from the 8th edge.
REQ-032 SHALL cover: the same sequence with LSB-first and 2 idle cycles inserted after bit 3 -> Q=8'hB6, busy=1 during the gap.
REQ-033 SHALL cover: out_ready=0 with two frames sent (8'h6D then 8'hFF) -> Q stays 8'h6D, overrun=1; then clr -> overrun=0, out_valid=0.
REQ-034 SHALL cover: sys_rst asserted after 5 bits, then 8 new bits 8'hA5 -> Q=8'hA5 with no residue from the aborted frame.
REQ-035 SHALL cover: with SREG_DESER_PARITY_EN, data 8'h6D (five 1s) with parity bit 1 -> delivered; with parity bit 0 -> parity_err pulse, out_valid stays 0.

Source files
------------

// File: rtl/sreg_pkg.sv
// rtl/sreg_pkg.sv - shared types and constants for the serial-to-parallel deserializer
package sreg_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

endpackage

// File: rtl/sreg_deserializer_if.sv
// rtl/sreg_deserializer_if.sv - parallel frame output handshake between deserializer and consumer
interface sreg_deserializer_if #(
    parameter int WIDTH = sreg_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] Q;
    logic             out_valid;
    logic             out_ready;

    modport master (output Q, output out_valid, input out_ready);
    modport slave  (input Q, input out_valid, output out_ready);
endinterface

// File: rtl/sreg_bit_counter.sv
// rtl/sreg_bit_counter.sv - frame bit counter 0..WIDTH-1 with clear, enable and terminal-count flag
module sreg_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST_IDX) ? '0 : count + CW'(1);
        end
    end

    assign tc = (count == LAST_IDX);
endmodule

// File: rtl/sreg_deserializer.sv
// rtl/sreg_deserializer.sv - serial-to-parallel deserializer with ready/valid frame output
// Optional even-parity bit per frame when SREG_DESER_PARITY_EN is defined.
module sreg_deserializer
    import sreg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 sin,
    input  logic                 msb_first,
    sreg_deserializer_if.master  out_if,
    output logic                 busy,
    output logic                 overrun,
    output logic                 parity_err
);
    state_t           state, state_next;
    logic [WIDTH-1:0] sr, sr_next, deliver_data;
    logic             order_q, cur_order;
    logic             shift_en, deliver, last_bit;
`ifdef SREG_DESER_PARITY_EN
    logic             par_fail;
    logic             perr_q;
`endif

    sreg_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (clr),
        .en      (shift_en),
        .tc      (last_bit)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (en) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (en && last_bit) begin
`ifdef SREG_DESER_PARITY_EN
                    state_next = ST_PAR;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef SREG_DESER_PARITY_EN
            ST_PAR:   if (en) state_next = ST_IDLE;
`endif
            default:  state_next = ST_IDLE;
        endcase
    end

    // The first bit of a frame uses the live msb_first; later bits use the latched order.
    always_comb begin
        busy      = (state != ST_IDLE);
        shift_en  = en && ((state == ST_IDLE) || (state == ST_SHIFT));
        cur_order = (state == ST_IDLE) ? msb_first : order_q;
        sr_next   = cur_order ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
`ifdef SREG_DESER_PARITY_EN
        par_fail     = (state == ST_PAR) && en && ((^sr) != sin);
        deliver      = (state == ST_PAR) && en && ((^sr) == sin);
        deliver_data = sr;
`else
        deliver      = (state == ST_SHIFT) && en && last_bit;
        deliver_data = sr_next;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sr      <= '0;
            order_q <= 1'b1;
        end else if (shift_en && !clr) begin
            sr <= sr_next;
            if (state == ST_IDLE) order_q <= msb_first;
        end
    end

    // A completing frame may replace Q only if the old one is gone or leaving on this edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_if.Q         <= '0;
            out_if.out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else if (clr) begin
            out_if.out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else if (deliver) begin
            if (!out_if.out_valid || out_if.out_ready) begin
                out_if.Q         <= deliver_data;
                out_if.out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_if.out_valid && out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
        end
    end

`ifdef SREG_DESER_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= par_fail;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sreg_deserializer.sv
// tb/tb_sreg_deserializer.sv - directed self-checking bench for sreg_deserializer
// Frames carry a trailing even-parity bit when SREG_DESER_PARITY_EN is defined.
module tb_sreg_deserializer;
    logic sys_clk = 1'b0;
    logic sys_rst, clr, en, sin, msb_first;
    logic busy, overrun, parity_err;
    int   n_cmp = 0;
    int   n_err = 0;

    sreg_deserializer_if #(.WIDTH(8)) dif ();

    sreg_deserializer #(.WIDTH(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .clr        (clr),
        .en         (en),
        .sin        (sin),
        .msb_first  (msb_first),
        .out_if     (dif),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic e, input logic s, input logic r);
        @(negedge sys_clk);
        en            = e;
        sin           = s;
        dif.out_ready = r;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_rst();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        en      = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic pulse_clr(input logic e, input logic s);
        @(negedge sys_clk);
        clr = 1'b1;
        en  = e;
        sin = s;
        @(posedge sys_clk);
        #1;
        clr = 1'b0;
    endtask

    // pat is the expected Q; bits go out in the order that rebuilds it
    task automatic send_bits(input logic [7:0] pat, input logic msb, input logic rdy_mid,
                             input logic rdy8, input int gap_at);
        logic b;
        msb_first = msb;
        for (int i = 0; i < 8; i++) begin
            b = msb ? pat[7-i] : pat[i];
            tick(1'b1, b, (i == 7) ? rdy8 : rdy_mid);
            if (gap_at > 0 && i == gap_at - 1) begin
                msb_first = ~msb;
                repeat (2) begin
                    tick(1'b0, 1'b0, rdy_mid);
                    chk("gap_busy", busy, 1);
                end
            end
        end
        msb_first = msb;
    endtask

    task automatic send_frame(input logic [7:0] pat, input logic msb, input logic rdy_mid,
                              input logic rdy_last, input int gap_at);
`ifdef SREG_DESER_PARITY_EN
        send_bits(pat, msb, rdy_mid, rdy_mid, gap_at);
        tick(1'b1, ^pat, rdy_last);
`else
        send_bits(pat, msb, rdy_mid, rdy_last, gap_at);
`endif
    endtask

    initial begin
        sys_rst = 1'b1; clr = 1'b0; en = 1'b0; sin = 1'b0; msb_first = 1'b1;
        dif.out_ready = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_q", dif.Q, 8'h00);
        chk("rst_valid", dif.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_perr", parity_err, 0);
        sys_rst = 1'b0;

        // MSB-first 0,1,1,0,1,1,0,1 with consumer ready
        send_frame(8'h6D, 1'b1, 1'b1, 1'b1, 0);
        chk("msb_q", dif.Q, 8'h6D);
        chk("msb_valid", dif.out_valid, 1);
        chk("msb_busy_done", busy, 0);
        tick(1'b0, 1'b0, 1'b1);
        chk("msb_valid_drop", dif.out_valid, 0);

        // LSB-first, same bit sequence, two idle cycles after bit 3
        send_frame(8'hB6, 1'b0, 1'b1, 1'b1, 3);
        chk("lsb_q", dif.Q, 8'hB6);
        chk("lsb_valid", dif.out_valid, 1);
        tick(1'b0, 1'b0, 1'b1);
        chk("lsb_valid_drop", dif.out_valid, 0);

        // overrun: two frames without consumer
        send_frame(8'h6D, 1'b1, 1'b0, 1'b0, 0);
        chk("ovr_q1", dif.Q, 8'h6D);
        chk("ovr_flag1", overrun, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0);
        chk("ovr_q2", dif.Q, 8'h6D);
        chk("ovr_flag2", overrun, 1);
        chk("ovr_valid2", dif.out_valid, 1);
        pulse_clr(1'b0, 1'b0);
        chk("clr_overrun", overrun, 0);
        chk("clr_valid", dif.out_valid, 0);
        chk("clr_q_kept", dif.Q, 8'h6D);

        // completion coincident with acceptance reloads and stays valid
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 0);
        chk("coin_q", dif.Q, 8'hC3);
        chk("coin_valid", dif.out_valid, 1);
        chk("coin_overrun", overrun, 0);
        tick(1'b0, 1'b0, 1'b1);
        chk("coin_drain", dif.out_valid, 0);

        // reset after 5 bits, then fresh frames back to back
        msb_first = 1'b1;
        repeat (5) tick(1'b1, 1'b1, 1'b1);
        chk("part_busy", busy, 1);
        do_rst();
        chk("mrst_busy", busy, 0);
        chk("mrst_q", dif.Q, 8'h00);
        chk("mrst_valid", dif.out_valid, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
        chk("a5_q", dif.Q, 8'hA5);
        chk("a5_valid", dif.out_valid, 1);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 0);
        chk("b2b_q", dif.Q, 8'h5A);
        chk("b2b_valid", dif.out_valid, 1);

        // clr mid-frame wins over a simultaneous en strobe
        msb_first = 1'b0;
        repeat (3) tick(1'b1, 1'b0, 1'b1);
        pulse_clr(1'b1, 1'b1);
        chk("clr_busy", busy, 0);
        chk("clr_valid_mid", dif.out_valid, 0);
        send_frame(8'h96, 1'b0, 1'b1, 1'b1, 0);
        chk("after_clr_q", dif.Q, 8'h96);

`ifdef SREG_DESER_PARITY_EN
        tick(1'b0, 1'b0, 1'b1);
        send_bits(8'h6D, 1'b1, 1'b1, 1'b1, 0);
        chk("par_wait_busy", busy, 1);
        chk("par_wait_valid", dif.out_valid, 0);
        tick(1'b1, 1'b1, 1'b1);
        chk("par_ok_q", dif.Q, 8'h6D);
        chk("par_ok_valid", dif.out_valid, 1);
        chk("par_ok_perr", parity_err, 0);
        send_bits(8'h6D, 1'b1, 1'b1, 1'b1, 0);
        tick(1'b1, 1'b0, 1'b1);
        chk("par_bad_perr", parity_err, 1);
        chk("par_bad_valid", dif.out_valid, 0);
        chk("par_bad_busy", busy, 0);
        tick(1'b0, 1'b0, 1'b1);
        chk("par_pulse_end", parity_err, 0);
`else
        tick(1'b0, 1'b0, 1'b1);
        chk("no_par_perr", parity_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
